// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, load FSM states, word alignment.
// The store path imports the same package, so keep it free of load-only logic.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ld_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = off[0];
    else if (f3 == F3_LW)                mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Core-side load request/response and data-memory read channel of the load unit.
// slave = the load unit itself; master = the core plus data memory driving it.
interface load_unit_if;
  import lsu_pkg::*;

  // Handshakes:
  //   ld_valid/ld_ready : a request transfers on a rising edge with both high;
  //                       ld_addr/ld_funct3 are sampled at that edge only.
  //   mem_req/mem_gnt   : the read issues on an edge with both high; mem_req and
  //                       mem_addr stay stable until then.
  //   mem_rvalid        : single-cycle data strobe, no back-pressure; may coincide
  //                       with mem_gnt.
  //   rd_valid          : single-cycle result strobe, no back-pressure; ld_err
  //                       qualifies it.
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        ld_err;
  logic        busy;
  ld_state_e   dbg_state;

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, mem_req, mem_addr, rd_valid, rd_data, ld_err, busy, dbg_state
  );

  modport master (
    output ld_valid, ld_addr, ld_funct3, mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, mem_req, mem_addr, rd_valid, rd_data, ld_err, busy, dbg_state
  );

endinterface

// File: rtl/load_format.sv
// Selects the addressed byte/halfword/word from a returned memory word and
// sign- or zero-extends it to 32 bits.
module load_format
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (offset)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
  end

  // offset[0] is deliberately ignored here: an odd halfword address truncates.
  assign half_v = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  result = {24'h0, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LHU:  result = {16'h0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts a core load, issues a word-aligned memory read, formats the result.
// Optional misaligned-access trap is enabled by defining LOAD_MISALIGN_TRAP_EN.
module load_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  load_unit_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  ld_state_e   state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ld_err_q, ld_err_d;
  logic [31:0] fmt_data;
  logic        req_bad;

  load_format u_format (
    .rdata  (bus.mem_rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .result (fmt_data)
  );

`ifdef LOAD_MISALIGN_TRAP_EN
  assign req_bad = !f3_is_legal(bus.ld_funct3) ||
                   is_misaligned(bus.ld_funct3, bus.ld_addr[1:0]);
`else
  assign req_bad = !f3_is_legal(bus.ld_funct3);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      cnt_q      <= 8'h0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ld_err_q   <= ld_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    off_d      = off_q;
    f3_d       = f3_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    ld_err_d   = ld_err_q;

    case (state_q)
      IDLE: begin
        if (bus.ld_valid) begin
          off_d = bus.ld_addr[1:0];
          f3_d  = bus.ld_funct3;
          if (req_bad) begin
            state_d    = DONE;
            rd_valid_d = 1'b1;
            rd_data_d  = 32'h0;
            ld_err_d   = 1'b1;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = word_align(bus.ld_addr);
            cnt_d      = 8'h0;
          end
        end
      end

      REQ: begin
        // Returned data wins over a timeout expiring in the same cycle.
        if (bus.mem_gnt && bus.mem_rvalid) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          rd_valid_d = 1'b1;
          rd_data_d  = fmt_data;
          ld_err_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          rd_valid_d = 1'b1;
          rd_data_d  = 32'h0;
          ld_err_d   = 1'b1;
        end else if (bus.mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          cnt_d     = cnt_q + 8'h1;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end

      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d    = DONE;
          rd_valid_d = 1'b1;
          rd_data_d  = fmt_data;
          ld_err_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d    = DONE;
          rd_valid_d = 1'b1;
          rd_data_d  = 32'h0;
          ld_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end

      DONE: begin
        state_d  = IDLE;
        ld_err_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ld_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed scoreboard bench for load_unit: a main instance (default timeout)
// and a second instance with TIMEOUT_CYC=4 for the abort path.
module tb_load_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t exp_to_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_unit_if lu_if();
  load_unit_if to_if();

  load_unit #(.TIMEOUT_CYC(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lu_if)
  );

  load_unit #(.TIMEOUT_CYC(4)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (to_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every rd_valid pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (rst_n && lu_if.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", lu_if.rd_data, e.data);
        chk("ld_err", {31'b0, lu_if.ld_err}, {31'b0, e.err});
        chk("rd_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon_to
    exp_t e;
    if (rst_n && to_if.rd_valid) begin
      if (exp_to_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL to_unexpected_rd_valid: got rd_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = exp_to_q.pop_front();
        chk("to_rd_data", to_if.rd_data, e.data);
        chk("to_ld_err", {31'b0, to_if.ld_err}, {31'b0, e.err});
        chk("to_rd_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request; n returns the accept cycle.
  task automatic issue(input logic [31:0] addr, input logic [2:0] f3, output int n);
    int w;
    w = 0;
    while (!lu_if.ld_ready && w < 20) begin
      step();
      w++;
    end
    chk("ld_ready_wait", {31'b0, lu_if.ld_ready}, 32'h1);
    lu_if.ld_valid  = 1'b1;
    lu_if.ld_addr   = addr;
    lu_if.ld_funct3 = f3;
    n = cyc;
    step();
    lu_if.ld_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      step();
      w++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  // gnt_wait cycles with gnt low, then gnt; rvalid with gnt (split=0) or one cycle later.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp_addr, input logic [31:0] rdata,
                          input int gnt_wait, input bit split, input logic [31:0] exp_data);
    int n;
    issue(addr, f3, n);
    exp_q.push_back('{data: exp_data, err: 1'b0, cyc: n + 1 + gnt_wait + (split ? 2 : 1)});
    for (int i = 0; i < gnt_wait; i++) begin
      chk("mem_req_hold", {31'b0, lu_if.mem_req}, 32'h1);
      chk("mem_addr_hold", lu_if.mem_addr, exp_addr);
      step();
    end
    chk("mem_req", {31'b0, lu_if.mem_req}, 32'h1);
    chk("mem_addr", lu_if.mem_addr, exp_addr);
    lu_if.mem_gnt = 1'b1;
    if (!split) begin
      lu_if.mem_rvalid = 1'b1;
      lu_if.mem_rdata  = rdata;
    end
    step();
    lu_if.mem_gnt    = 1'b0;
    lu_if.mem_rvalid = 1'b0;
    chk("mem_req_drop", {31'b0, lu_if.mem_req}, 32'h0);
    if (split) begin
      lu_if.mem_rvalid = 1'b1;
      lu_if.mem_rdata  = rdata;
      step();
      lu_if.mem_rvalid = 1'b0;
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    lu_if.ld_valid = 1'b0; lu_if.ld_addr = 32'h0; lu_if.ld_funct3 = 3'b000;
    lu_if.mem_gnt = 1'b0; lu_if.mem_rvalid = 1'b0; lu_if.mem_rdata = 32'h0;
    to_if.ld_valid = 1'b0; to_if.ld_addr = 32'h0; to_if.ld_funct3 = 3'b000;
    to_if.mem_gnt = 1'b0; to_if.mem_rvalid = 1'b0; to_if.mem_rdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_ready", {31'b0, lu_if.ld_ready}, 32'h1);
    chk("rst_busy", {31'b0, lu_if.busy}, 32'h0);
    chk("rst_mem_req", {31'b0, lu_if.mem_req}, 32'h0);
    chk("rst_mem_addr", lu_if.mem_addr, 32'h0);
    chk("rst_rd_valid", {31'b0, lu_if.rd_valid}, 32'h0);
    chk("rst_rd_data", lu_if.rd_data, 32'h0);
    chk("rst_ld_err", {31'b0, lu_if.ld_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // LB from top byte, gnt then rvalid: rd_valid at N+3.
    run_load(32'h0000_0103, F3_LB,  32'h0000_0100, 32'h80AA_BB11, 0, 1'b1, 32'hFFFF_FF80);
    // Same-cycle gnt/rvalid: rd_valid at N+2.
    run_load(32'h0000_0202, F3_LHU, 32'h0000_0200, 32'h9234_5678, 0, 1'b0, 32'h0000_9234);
    run_load(32'h0000_0202, F3_LH,  32'h0000_0200, 32'h9234_5678, 0, 1'b0, 32'hFFFF_9234);
    run_load(32'h0000_0101, F3_LBU, 32'h0000_0100, 32'h80AA_BB11, 0, 1'b0, 32'h0000_00BB);
    run_load(32'h0000_0101, F3_LB,  32'h0000_0100, 32'h80AA_BB11, 0, 1'b1, 32'hFFFF_FFBB);
    run_load(32'h0000_0102, F3_LB,  32'h0000_0100, 32'h80AA_BB11, 1, 1'b0, 32'hFFFF_FFAA);
    run_load(32'h0000_0100, F3_LBU, 32'h0000_0100, 32'h80AA_BB11, 0, 1'b0, 32'h0000_0011);
    run_load(32'h0000_0200, F3_LH,  32'h0000_0200, 32'h1234_8765, 0, 1'b1, 32'hFFFF_8765);

    // Misaligned word.
`ifdef LOAD_MISALIGN_TRAP_EN
    issue(32'h0000_0041, F3_LW, n);
    exp_q.push_back('{data: 32'h0, err: 1'b1, cyc: n + 1});
    chk("misalign_no_req", {31'b0, lu_if.mem_req}, 32'h0);
    drain();
`else
    run_load(32'h0000_0041, F3_LW, 32'h0000_0040, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D);
`endif

    // Illegal funct3: error one cycle after accept, no memory access.
    issue(32'h0000_0080, 3'b011, n);
    exp_q.push_back('{data: 32'h0, err: 1'b1, cyc: n + 1});
    chk("illegal_no_req", {31'b0, lu_if.mem_req}, 32'h0);
    chk("illegal_not_ready", {31'b0, lu_if.ld_ready}, 32'h0);
    drain();
    chk("illegal_idle_busy", {31'b0, lu_if.busy}, 32'h0);

    // LW with gnt held off three cycles.
    run_load(32'h0000_0040, F3_LW, 32'h0000_0040, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF);

    // Reset while in WAIT, then a late rvalid.
    issue(32'h0000_0080, F3_LW, n);
    lu_if.mem_gnt = 1'b1;
    step();
    lu_if.mem_gnt = 1'b0;
    chk("wait_busy", {31'b0, lu_if.busy}, 32'h1);
    chk("wait_rd_data_before_rst", lu_if.rd_data, 32'hDEAD_BEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, lu_if.busy}, 32'h0);
    chk("midrst_mem_req", {31'b0, lu_if.mem_req}, 32'h0);
    chk("midrst_mem_addr", lu_if.mem_addr, 32'h0);
    chk("midrst_rd_valid", {31'b0, lu_if.rd_valid}, 32'h0);
    chk("midrst_rd_data", lu_if.rd_data, 32'h0);
    chk("midrst_ld_err", {31'b0, lu_if.ld_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    lu_if.mem_rvalid = 1'b1;
    lu_if.mem_rdata  = 32'h5555_AAAA;
    step();
    lu_if.mem_rvalid = 1'b0;
    repeat (4) step();
    chk("postrst_busy", {31'b0, lu_if.busy}, 32'h0);
    chk("postrst_rd_data", lu_if.rd_data, 32'h0);

    // Timeout instance: gnt but never rvalid; aborts after 4 REQ/WAIT cycles.
    to_if.ld_valid  = 1'b1;
    to_if.ld_addr   = 32'h0000_0300;
    to_if.ld_funct3 = F3_LW;
    n = cyc;
    step();
    to_if.ld_valid = 1'b0;
    exp_to_q.push_back('{data: 32'h0, err: 1'b1, cyc: n + 5});
    chk("to_mem_req", {31'b0, to_if.mem_req}, 32'h1);
    chk("to_mem_addr", to_if.mem_addr, 32'h0000_0300);
    to_if.mem_gnt = 1'b1;
    step();
    to_if.mem_gnt = 1'b0;
    chk("to_mem_req_drop", {31'b0, to_if.mem_req}, 32'h0);
    repeat (6) step();
    chk("to_pending", 32'(exp_to_q.size()), 32'h0);
    chk("to_idle", {31'b0, to_if.busy}, 32'h0);
    to_if.mem_rvalid = 1'b1;
    to_if.mem_rdata  = 32'h1234_5678;
    step();
    to_if.mem_rvalid = 1'b0;
    repeat (4) step();
    chk("to_stray_busy", {31'b0, to_if.busy}, 32'h0);
    chk("to_stray_rd_data", to_if.rd_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
